// File: rtl/pc_branch_unit_if.sv
// Bus interface for pc_branch_unit: run control, branch request, flag
// capture, target-LUT write port and the PC/status outputs.
// The slave modport is the PC stage; the master modport is its driver.
interface pc_branch_unit_if #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16
);
    localparam int LUT_AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

    logic              start;
    logic              halt;
    logic              stall;
    logic              flag_we;
    logic              equal_in;
    logic              less_in;
    logic [2:0]        br_mode;
    logic [7:0]        br_offset;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [PC_W-1:0]   lut_wdata;
    logic [PC_W-1:0]   pc;
    logic              running;
    logic              done;
    logic              taken;
    logic              flag_eq;
    logic              flag_lt;

    modport slave (
        input  start, halt, stall, flag_we, equal_in, less_in,
               br_mode, br_offset, lut_we, lut_waddr, lut_wdata,
        output pc, running, done, taken, flag_eq, flag_lt
    );

    modport master (
        output start, halt, stall, flag_we, equal_in, less_in,
               br_mode, br_offset, lut_we, lut_waddr, lut_wdata,
        input  pc, running, done, taken, flag_eq, flag_lt
    );
endinterface

// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution stage behind the 8-bit ALU.
// Holds the compare flags, resolves branches on the registered flags and
// runs the start/run/done program handshake.
// Optional feature macro: BRANCH_LUT_EN (absolute branch targets from a
// register LUT instead of PC-relative offsets).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | out of reset; pc parked at RESET_PC, waiting for start
// RUN   | program executing; pc advances or branches when not stalled
// DONE  | HALT retired; pc shows the halt address until the next start
module pc_branch_unit #(
    parameter int PC_W      = 10,
    parameter int RESET_PC  = 0,
    parameter int LUT_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_branch_unit_if.slave       bus
);
    localparam int LUT_AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
    localparam logic [PC_W-1:0] PC_START = PC_W'(RESET_PC);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] BR_BEQ = 3'b001;
    localparam logic [2:0] BR_BNE = 3'b010;
    localparam logic [2:0] BR_BLT = 3'b011;
    localparam logic [2:0] BR_BLE = 3'b100;
    localparam logic [2:0] BR_JMP = 3'b101;

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_flag_eq;
    logic            r_flag_lt;

    logic            w_run;
    logic            w_cond;
    logic            w_taken;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_next;

    assign w_run = (r_state == ST_RUN);

    // Branch condition on the registered flags; a compare in this same
    // cycle only lands at the edge, so it cannot affect this decision.
    always_comb begin
        w_cond = 1'b0;
        case (bus.br_mode)
            BR_BEQ:  w_cond = r_flag_eq;
            BR_BNE:  w_cond = ~r_flag_eq;
            BR_BLT:  w_cond = r_flag_lt;
            BR_BLE:  w_cond = r_flag_lt | r_flag_eq;
            BR_JMP:  w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    // halt and stall both suppress the redirect
    assign w_taken = w_run & ~bus.stall & ~bus.halt & w_cond;

`ifdef BRANCH_LUT_EN
    logic [PC_W-1:0] r_lut [LUT_DEPTH];
    logic            w_unused_offset;

    // Target LUT; writable in any state, read combinationally so a
    // same-cycle write is only seen by later branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_lut[i] <= '0;
            end
        end else if (bus.lut_we) begin
            r_lut[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    assign w_target        = r_lut[bus.br_offset[LUT_AW-1:0]];
    assign w_unused_offset = ^bus.br_offset[7:LUT_AW];
`else
    logic w_unused_lut;

    // Relative target, silently wrapping modulo 2^PC_W
    assign w_target     = r_pc + {{(PC_W-8){bus.br_offset[7]}}, bus.br_offset};
    assign w_unused_lut = ^{bus.lut_we, bus.lut_waddr, bus.lut_wdata};
`endif

    assign w_pc_next = w_taken ? w_target : r_pc + 1'b1;

    // Run/halt FSM together with the PC and flag registers it gates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= PC_START;
            r_flag_eq <= 1'b0;
            r_flag_lt <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // start is honoured even while stall is high
                    if (bus.start) begin
                        r_state   <= ST_RUN;
                        r_pc      <= PC_START;
                        r_flag_eq <= 1'b0;
                        r_flag_lt <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (bus.flag_we) begin
                            r_flag_eq <= bus.equal_in;
                            r_flag_lt <= bus.less_in;
                        end
                        if (bus.halt) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_pc <= w_pc_next;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_pc    <= PC_START;
                end
            endcase
        end
    end

    assign bus.pc      = r_pc;
    assign bus.running = w_run;
    assign bus.done    = (r_state == ST_DONE);
    assign bus.taken   = w_taken;
    assign bus.flag_eq = r_flag_eq;
    assign bus.flag_lt = r_flag_lt;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios plus a
// randomized run against a behavioural model of the PC stage.
module tb_pc_branch_unit;
    localparam int PC_W      = 10;
    localparam int LUT_DEPTH = 16;
    localparam int MASK      = (1 << PC_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_branch_unit_if #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH)) bif ();

    pc_branch_unit #(.PC_W(PC_W), .RESET_PC(0), .LUT_DEPTH(LUT_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_pass  = 0;
    int n_total = 0;

    // behavioural model
    bit m_run, m_done, m_eq, m_lt, m_taken;
    int m_pc;
    int m_lut [LUT_DEPTH];
    logic obs_taken;

    task automatic model_reset();
        m_run = 0; m_done = 0; m_pc = 0; m_eq = 0; m_lt = 0; m_taken = 0;
        for (int i = 0; i < LUT_DEPTH; i++) m_lut[i] = 0;
    endtask

    task automatic idle_inputs();
        bif.start = 0; bif.halt = 0; bif.stall = 0; bif.flag_we = 0;
        bif.equal_in = 0; bif.less_in = 0; bif.br_mode = 3'd0;
        bif.br_offset = 8'd0; bif.lut_we = 0; bif.lut_waddr = '0;
        bif.lut_wdata = '0;
    endtask

    // One clock: drive at negedge, sample taken, advance model at posedge,
    // return at the next negedge. LUT inputs are taken from bif as set.
    task automatic drive(input bit st, input bit hl, input bit sl, input bit fw,
                         input bit eq, input bit lt, input logic [2:0] md,
                         input logic [7:0] off);
        bit cond;
        int tgt;
        int so;
        logic [3:0] idx;
        bit lw;
        int la, ld;
        bif.start = st; bif.halt = hl; bif.stall = sl; bif.flag_we = fw;
        bif.equal_in = eq; bif.less_in = lt; bif.br_mode = md; bif.br_offset = off;
        lw = bif.lut_we; la = int'(bif.lut_waddr); ld = int'(bif.lut_wdata);
        case (md)
            3'd1: cond = m_eq;
            3'd2: cond = !m_eq;
            3'd3: cond = m_lt;
            3'd4: cond = m_lt || m_eq;
            3'd5: cond = 1;
            default: cond = 0;
        endcase
        so = $signed(off);
        idx = off[3:0];
`ifdef BRANCH_LUT_EN
        tgt = m_lut[idx];
`else
        tgt = (m_pc + so) & MASK;
`endif
        m_taken = m_run && !sl && !hl && cond;
        #1 obs_taken = bif.taken;
        @(posedge clk);
        if (m_run) begin
            if (!sl) begin
                if (fw) begin m_eq = eq; m_lt = lt; end
                if (hl) begin m_run = 0; m_done = 1; end
                else m_pc = m_taken ? tgt : ((m_pc + 1) & MASK);
            end
        end else if (st) begin
            m_run = 1; m_done = 0; m_pc = 0; m_eq = 0; m_lt = 0;
        end
`ifdef BRANCH_LUT_EN
        if (lw) m_lut[la] = ld;
`endif
        @(negedge clk);
        bif.lut_we = 0;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 3'd0, 8'd0);
    endtask

    task automatic restart();
        if (m_run) drive(0, 1, 0, 0, 0, 0, 3'd0, 8'd0);
        drive(1, 0, 0, 0, 0, 0, 3'd0, 8'd0);
    endtask

    task automatic walk_to(input int target);
        int guard = 0;
        while (m_pc != target && m_run && guard < 3000) begin
            nop();
            guard++;
        end
        n_total++;
        if (m_pc != target || bif.pc !== PC_W'(target)) $display("FAIL walk_to: pc %0d required %0d", bif.pc, target);
        else n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        n_total++; if (bif.pc !== '0) $display("FAIL reset_pc: got %0h want 0", bif.pc); else n_pass++;
        n_total++; if (bif.running !== 1'b0) $display("FAIL reset_running: got %b want 0", bif.running); else n_pass++;
        n_total++; if (bif.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bif.done); else n_pass++;
        n_total++; if (bif.taken !== 1'b0) $display("FAIL reset_taken: got %b want 0", bif.taken); else n_pass++;
        n_total++; if ({bif.flag_eq, bif.flag_lt} !== 2'b00) $display("FAIL reset_flags: got %b%b want 00", bif.flag_eq, bif.flag_lt); else n_pass++;
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_start();
        drive(1, 0, 0, 0, 0, 0, 3'd0, 8'd0);
        n_total++; if (bif.running !== 1'b1) $display("FAIL start_running: got %b want 1", bif.running); else n_pass++;
        n_total++; if (bif.pc !== 10'd0) $display("FAIL start_pc: got %0d want 0", bif.pc); else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            nop();
            n_total++; if (bif.pc !== PC_W'(i)) $display("FAIL start_step: got %0d want %0d", bif.pc, i); else n_pass++;
        end
    endtask

    task automatic test_relative_branch();
        restart();
        walk_to(5);
        drive(0, 0, 0, 1, 1, 0, 3'd0, 8'd0);
        drive(0, 0, 0, 0, 0, 0, 3'd1, 8'hFD);
        n_total++; if (obs_taken !== m_taken) $display("FAIL beq_taken: got %b want %b", obs_taken, m_taken); else n_pass++;
        n_total++; if (bif.pc !== PC_W'(m_pc)) $display("FAIL beq_pc: got %0d want %0d", bif.pc, m_pc); else n_pass++;
`ifndef BRANCH_LUT_EN
        n_total++; if (bif.pc !== 10'd3) $display("FAIL beq_pc_abs: got %0d want 3", bif.pc); else n_pass++;
`endif
        walk_to(5);
        drive(0, 0, 0, 0, 0, 0, 3'd2, 8'hFD);
        n_total++; if (obs_taken !== 1'b0) $display("FAIL bne_taken: got %b want 0", obs_taken); else n_pass++;
        n_total++; if (bif.pc !== 10'd6) $display("FAIL bne_pc: got %0d want 6", bif.pc); else n_pass++;
    endtask

    task automatic test_same_cycle_flag();
        int p;
        restart();
        p = m_pc;
        drive(0, 0, 0, 1, 1, 0, 3'd1, 8'h04);
        n_total++; if (obs_taken !== 1'b0) $display("FAIL samecyc_taken: got %b want 0", obs_taken); else n_pass++;
        n_total++; if (bif.pc !== PC_W'(p + 1)) $display("FAIL samecyc_pc: got %0d want %0d", bif.pc, p + 1); else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 3'd1, 8'h04);
        n_total++; if (obs_taken !== 1'b1) $display("FAIL next_beq_taken: got %b want 1", obs_taken); else n_pass++;
        n_total++; if (bif.pc !== PC_W'(m_pc)) $display("FAIL next_beq_pc: got %0d want %0d", bif.pc, m_pc); else n_pass++;
    endtask

    task automatic test_stall_halt();
        restart();
        drive(0, 0, 0, 1, 0, 1, 3'd0, 8'd0);
        walk_to(7);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 1, 0, 3'd5, 8'h10);
            n_total++; if (obs_taken !== 1'b0) $display("FAIL stall_taken: got %b want 0", obs_taken); else n_pass++;
            n_total++; if (bif.pc !== 10'd7) $display("FAIL stall_pc: got %0d want 7", bif.pc); else n_pass++;
            n_total++; if ({bif.flag_eq, bif.flag_lt} !== 2'b01) $display("FAIL stall_flags: got %b%b want 01", bif.flag_eq, bif.flag_lt); else n_pass++;
        end
        drive(0, 1, 0, 0, 0, 0, 3'd5, 8'h10);
        n_total++; if (obs_taken !== 1'b0) $display("FAIL halt_taken: got %b want 0", obs_taken); else n_pass++;
        n_total++; if (bif.done !== 1'b1 || bif.running !== 1'b0) $display("FAIL halt_state: got done=%b run=%b want done=1 run=0", bif.done, bif.running); else n_pass++;
        n_total++; if (bif.pc !== 10'd7) $display("FAIL halt_pc: got %0d want 7", bif.pc); else n_pass++;
        nop();
        n_total++; if (bif.done !== 1'b1 || bif.pc !== 10'd7) $display("FAIL done_hold: got done=%b pc=%0d want done=1 pc=7", bif.done, bif.pc); else n_pass++;
        drive(1, 0, 1, 0, 0, 0, 3'd0, 8'd0);
        n_total++; if (bif.running !== 1'b1 || bif.done !== 1'b0) $display("FAIL restart_state: got run=%b done=%b want run=1 done=0", bif.running, bif.done); else n_pass++;
        n_total++; if (bif.pc !== 10'd0) $display("FAIL restart_pc: got %0d want 0", bif.pc); else n_pass++;
        n_total++; if ({bif.flag_eq, bif.flag_lt} !== 2'b00) $display("FAIL restart_flags: got %b%b want 00", bif.flag_eq, bif.flag_lt); else n_pass++;
    endtask

    task automatic test_wrap();
        restart();
        walk_to(1022);
        drive(0, 0, 0, 0, 0, 0, 3'd5, 8'h02);
        n_total++; if (bif.pc !== PC_W'(m_pc)) $display("FAIL jmp_wrap: got %0d want %0d", bif.pc, m_pc); else n_pass++;
`ifndef BRANCH_LUT_EN
        n_total++; if (bif.pc !== 10'd0) $display("FAIL jmp_wrap_abs: got %0d want 0", bif.pc); else n_pass++;
`endif
        walk_to(1023);
        nop();
        n_total++; if (bif.pc !== 10'd0) $display("FAIL inc_wrap: got %0d want 0", bif.pc); else n_pass++;
    endtask

`ifdef BRANCH_LUT_EN
    task automatic test_lut();
        restart();
        bif.lut_we = 1; bif.lut_waddr = 4'd3; bif.lut_wdata = 10'h2A0;
        drive(0, 0, 0, 1, 0, 1, 3'd0, 8'd0);
        drive(0, 0, 0, 0, 0, 0, 3'd3, 8'd3);
        n_total++; if (bif.pc !== 10'h2A0) $display("FAIL lut_blt: got %0h want 2a0", bif.pc); else n_pass++;
        bif.lut_we = 1; bif.lut_waddr = 4'd3; bif.lut_wdata = 10'h155;
        drive(0, 0, 0, 0, 0, 0, 3'd3, 8'd3);
        n_total++; if (bif.pc !== 10'h2A0) $display("FAIL lut_old: got %0h want 2a0", bif.pc); else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 3'd3, 8'd3);
        n_total++; if (bif.pc !== 10'h155) $display("FAIL lut_new: got %0h want 155", bif.pc); else n_pass++;
    endtask
`endif

    task automatic test_reset_midrun();
        restart();
        drive(0, 0, 0, 1, 1, 1, 3'd0, 8'd0);
        walk_to(9);
        bif.br_mode = 3'd5;
        #2 rst_n = 0;
        #1;
        n_total++; if (bif.pc !== 10'd0 || bif.running !== 1'b0 || bif.done !== 1'b0) $display("FAIL midrun_reset: got pc=%0d run=%b done=%b want 0 0 0", bif.pc, bif.running, bif.done); else n_pass++;
        n_total++; if ({bif.flag_eq, bif.flag_lt, bif.taken} !== 3'b000) $display("FAIL midrun_reset_flags: got %b%b%b want 000", bif.flag_eq, bif.flag_lt, bif.taken); else n_pass++;
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            bif.lut_we    = ($urandom_range(0, 7) == 0);
            bif.lut_waddr = 4'($urandom);
            bif.lut_wdata = 10'($urandom);
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                  1'($urandom), 3'($urandom), 8'($urandom));
            n_total++; if (obs_taken !== m_taken) $display("FAIL rnd_taken[%0d]: got %b want %b", i, obs_taken, m_taken); else n_pass++;
            n_total++; if (bif.pc !== PC_W'(m_pc)) $display("FAIL rnd_pc[%0d]: got %0d want %0d", i, bif.pc, m_pc); else n_pass++;
            n_total++; if ({bif.running, bif.done} !== {m_run, m_done}) $display("FAIL rnd_state[%0d]: got %b%b want %b%b", i, bif.running, bif.done, m_run, m_done); else n_pass++;
            n_total++; if ({bif.flag_eq, bif.flag_lt} !== {m_eq, m_lt}) $display("FAIL rnd_flags[%0d]: got %b%b want %b%b", i, bif.flag_eq, bif.flag_lt, m_eq, m_lt); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_relative_branch();
        test_same_cycle_flag();
        test_stall_halt();
        test_wrap();
`ifdef BRANCH_LUT_EN
        test_lut();
`endif
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter and branch-resolution stage directly downstream of the 8-bit ALU. Latches the ALU's `equal`/`lessThan` compare outputs into a flag register, evaluates the current instruction's branch condition against those stored flags, and advances or redirects the PC every unstalled cycle. Also owns the program run/halt handshake with the testbench or top level: start, run, done.

## Interface

**Parameters**
- `PC_W`, 10: PC width in bits.
- `RESET_PC`, 0: PC value on reset and on every `start`.
- `LUT_DEPTH`, 16: branch-target LUT entries. Used only with `BRANCH_LUT_EN`.

**Ports**
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a program run.
- `halt` in 1: current instruction is HALT (from the decoder).
- `stall` in 1: freeze PC and flags this cycle.
- `flag_we` in 1: current instruction is a compare; capture the ALU flags.
- `equal_in` in 1: ALU `equal` output.
- `less_in` in 1: ALU `lessThan` output.
- `br_mode` in 3: 000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BLE, 101 JMP, 110/111 treated as none.
- `br_offset` in 8: signed PC offset, or LUT index (low log2(LUT_DEPTH) bits) with `BRANCH_LUT_EN`.
- `lut_we` in 1: LUT write enable (macro only).
- `lut_waddr` in log2(LUT_DEPTH): LUT write index (macro only).
- `lut_wdata` in PC_W: LUT write data (macro only).
- `pc` out PC_W: current instruction address.
- `running` out 1: FSM in RUN.
- `done` out 1: FSM in DONE.
- `taken` out 1: combinational; a branch is redirecting the PC this cycle.
- `flag_eq` out 1: stored equal flag.
- `flag_lt` out 1: stored less-than flag.

## Operation

**FSM states:** IDLE, RUN, DONE.
- **IDLE**
  - `start` → RUN.
  - `pc` holds `RESET_PC`.
- **RUN**
  - Advances the PC each cycle in which `stall`=0.
  - `halt`=1 with `stall`=0 → DONE. `pc` holds; the halt address stays visible.
  - `start` is ignored in RUN.
- **DONE**
  - `start` → RUN.
  - On this transition: `pc`←`RESET_PC`, flags←0.

**Branch conditions** (evaluated on the registered flags):
- BEQ: `flag_eq`
- BNE: !`flag_eq`
- BLT: `flag_lt`
- BLE: `flag_lt` | `flag_eq`
- JMP: always

**`taken` and next PC**
- `taken` = RUN & !`stall` & !`halt` & condition.
- Next PC = `taken` ? target : `pc`+1.
- All PC arithmetic is modulo 2^PC_W; wrap-around is silent.

**Flags**
- With `flag_we` & RUN & !`stall`: `flag_eq`←`equal_in`, `flag_lt`←`less_in`.
- A branch in the same cycle as `flag_we` uses the old flags.
- Both flags clear to 0 on reset and on `start`.

**Precedence and boundary rules**
- `halt` beats a branch.
- `stall` beats everything except reset.
- A `start` arriving in IDLE/DONE together with `stall` still takes effect.
- Reset mid-run: immediate return to IDLE with all outputs at their reset values.

## Timing

- Reset values:
  - `pc`=`RESET_PC`
  - `running`=0, `done`=0
  - `flag_eq`=0, `flag_lt`=0
  - `taken`=0
  - all LUT entries 0
- `start` at edge N:
  - `running`=1 after edge N.
  - First instruction is at `RESET_PC` during cycle N+1.
  - First PC change at edge N+1.
- Branch resolves in the same cycle it is presented: `taken` is combinational, and `pc`=target after the next edge. There is no delay slot.
- `halt` at edge H: `done`=1 and `running`=0 after H.
- Flag capture has a one-cycle latency: a compare at edge K is visible to a branch in cycle K+1.

## Configuration

- **`BRANCH_LUT_EN` defined**
  - Target = `lut[br_offset[log2(LUT_DEPTH)-1:0]]`, an absolute address.
  - LUT writes are registered. A write and a read of the same index in the same cycle returns the old entry.
  - Writes are accepted in any FSM state.
- **`BRANCH_LUT_EN` undefined**
  - Target = `pc` + sign-extend(`br_offset`).
  - The `lut_*` ports are present but ignored, and no LUT storage is built.

## Test plan

- **Reset and start:** `rst_n` low then high, `start` pulse → `pc`=0, `running`=1, then `pc` steps 0,1,2,3 over three unstalled cycles.
- **Relative branch** (no macro): at `pc`=5, `flag_we` with `equal_in`=1, next cycle BEQ with `br_offset`=0xFD → `taken`=1, `pc`=3. Repeat at `pc`=5 with BNE → `pc`=6.
- **Same-cycle flag write and branch:** flags 0, `flag_we`=1, `equal_in`=1, BEQ in the same cycle → `taken`=0, `pc`+1. The following BEQ is taken.
- **Stall and halt:** `stall`=1 for 3 cycles at `pc`=7 → `pc` holds 7 and flags unchanged. `halt`+JMP at `pc`=7 → `done`=1, `pc`=7, `taken`=0. New `start` → `pc`=0, flags 0.
- **Wrap-around:** at `pc`=1023 (PC_W=10) with no branch → `pc`=0. JMP with `br_offset`=0x02 at `pc`=1022 → `pc`=0.
- **LUT** (`BRANCH_LUT_EN`): write `lut[3]`=0x2A0, then BLT with `flag_lt`=1 and `br_offset`=3 → `pc`=0x2A0. Write and read index 3 in the same cycle → old target used. Asynchronous reset mid-run → `pc`=0, `running`=0.
